// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared 1024x768@60 raster timing constants for the VGA peripherals
package vga_timing_pkg;
  localparam int H_ACTIVE = 1024;
  localparam int H_FRONT  = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BACK   = 160;
  localparam int V_ACTIVE = 768;
  localparam int V_FRONT  = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BACK   = 29;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int H_W      = 11;
  localparam int V_W      = 10;
  localparam int PIX_W    = 10;
endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: enabled up-counter that returns to 0 after TERM, with a combinational wrap pulse
module wrap_counter #(
  parameter int           W    = 8,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = en && count == TERM;
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else if (en) count <= wrap ? '0 : count + W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster timing (sync, visible, coordinates, strobes, frame count, raster hit)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             polarity,
  input  logic [V_W-1:0]   raster_line,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic [PIX_W-1:0] pix_x,
  output logic [PIX_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank,
  output logic [7:0]       frame_count,
  output logic             raster_hit
);
  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
  localparam logic [H_W-1:0] H_ACT_C = H_W'(H_ACT);
  localparam logic [H_W-1:0] HS0_C   = H_W'(H_ACT + H_FP);
  localparam logic [H_W-1:0] HS1_C   = H_W'(H_ACT + H_FP + H_SW);
  localparam logic [V_W-1:0] V_ACT_C = V_W'(V_ACT);
  localparam logic [V_W-1:0] VS0_C   = V_W'(V_ACT + V_FP);
  localparam logic [V_W-1:0] VS1_C   = V_W'(V_ACT + V_FP + V_SW);
  if (H_ACT < 1 || H_FP < 1 || H_SW < 1 || H_BP < 1 || V_ACT < 1 || V_FP < 1 || V_SW < 1 ||
      V_BP < 1 || H_TOT >= 2048 || V_TOT >= 1024) begin : g_bad_params
    $error("vga_timing_gen: unsupported timing parameters");
  end
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic h_wrap, v_wrap, frame_wrap_q, h_vis, v_vis;
  wrap_counter #(.W(H_W), .TERM(H_W'(H_TOT - 1))) u_h (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .count(h), .wrap(h_wrap)
  );
  wrap_counter #(.W(V_W), .TERM(V_W'(V_TOT - 1))) u_v (
    .clk(clk), .rst_n(rst_n), .en(h_wrap), .count(v), .wrap(v_wrap)
  );
  assign h_vis = h < H_ACT_C;
  assign v_vis = v < V_ACT_C;
  // frame_wrap_q lines the frame_count bump up with the registered frame_start
  always_ff @(posedge clk)
    if (!rst_n) begin
      frame_wrap_q <= 1'b0;
      frame_count  <= '0;
      hsync        <= polarity;
      vsync        <= polarity;
      visible      <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank       <= 1'b0;
      raster_hit   <= 1'b0;
    end else begin
      frame_wrap_q <= v_wrap;
      frame_count  <= frame_count + 8'(frame_wrap_q);
      hsync        <= (h >= HS0_C && h < HS1_C) ^ polarity;
      vsync        <= (v >= VS0_C && v < VS1_C) ^ polarity;
      visible      <= h_vis && v_vis;
      pix_x        <= (h_vis && v_vis) ? h[PIX_W-1:0] : '0;
      pix_y        <= v_vis ? v : '0;
      line_start   <= h == '0;
      frame_start  <= h == '0 && v == '0;
      vblank       <= !v_vis;
      raster_hit   <= h == H_ACT_C && v == raster_line;
    end
endmodule
